// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder.
// The control side (master) drives enable, mode, in, last and div.
// The decoder (slave) returns out, sel, tick and wrap.
//   enable : 0 forces every output bit inactive and freezes the scan
//   mode   : 0 = direct index, 1 = self-stepping scan
//   in     : direct-mode index
//   last   : highest index visited in scan mode
//   div    : dwell time minus one, in enabled cycles
//   out    : registered one-hot (or one-cold) decode of sel
//   sel    : current index
//   tick   : one-cycle pulse when the scan index advanced
//   wrap   : one-cycle pulse when the index returned to 0
interface scan_decoder_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16
);
  logic                  enable;
  logic                  mode;
  logic [SEL_W-1:0]      in;
  logic [SEL_W-1:0]      last;
  logic [DIV_W-1:0]      div;
  logic [(2**SEL_W)-1:0] out;
  logic [SEL_W-1:0]      sel;
  logic                  tick;
  logic                  wrap;

  modport master (
    output enable, mode, in, last, div,
    input  out, sel, tick, wrap
  );

  modport slave (
    input  enable, mode, in, last, div,
    output out, sel, tick, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a built-in scan sequencer, for driving
// multiplexed loads such as 7-segment digit commons.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : scan_decoder_if slave (enable/mode/in/last/div in,
//         out/sel/tick/wrap out)
// Every output is a register, so there is no input-to-output
// combinational path.
module scan_decoder #(
  parameter int SEL_W      = 3,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic           clk,
  input  logic           rst,
  scan_decoder_if.slave  bus
);
  localparam int N = 2**SEL_W;

  logic [SEL_W-1:0] sel_q, sel_nxt;
  logic [DIV_W-1:0] pcnt_q, pcnt_nxt;
  logic [N-1:0]     out_q, out_nxt;
  logic             tick_q, tick_nxt;
  logic             wrap_q, wrap_nxt;

  // Output level with nothing selected, after polarity.
  function automatic logic [N-1:0] idle_level();
    return (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  endfunction

  // One-hot decode gated by enable, then polarity applied.
  function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] idx,
                                          input logic en);
    logic [N-1:0] d;
    d = '0;
    if (en) d[idx] = 1'b1;
    return (ACTIVE_LOW != 0) ? ~d : d;
  endfunction

  always_comb begin
    sel_nxt  = sel_q;
    pcnt_nxt = pcnt_q;
    tick_nxt = 1'b0;
    wrap_nxt = 1'b0;
    if (!bus.mode) begin
      // Direct mode tracks the input even while disabled.
      sel_nxt  = bus.in;
      pcnt_nxt = '0;
    end else if (bus.enable) begin
      // >= so a div or last lowered mid-dwell takes effect immediately.
      if (pcnt_q >= bus.div) begin
        pcnt_nxt = '0;
        tick_nxt = 1'b1;
        if (sel_q >= bus.last) begin
          sel_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          sel_nxt = sel_q + SEL_W'(1);
        end
      end else begin
        pcnt_nxt = pcnt_q + DIV_W'(1);
      end
    end
    // Decode the index sel takes at this edge so out and sel agree.
    out_nxt = decode(sel_nxt, bus.enable);
  end

  // Stage boundary: all state and outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      pcnt_q <= '0;
      out_q  <= idle_level();
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_nxt;
      pcnt_q <= pcnt_nxt;
      out_q  <= out_nxt;
      tick_q <= tick_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.out  = out_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
endmodule
